carousel_collector: RTL and testbench
=====================================

# carousel_collector

Serial-to-parallel gatherer that is the receive-side counterpart of the carousel rotator. It accepts one WIDTH-bit element per valid/ready handshake and assembles BUFFER_SIZE consecutive elements into a parallel frame. The frame is presented as an unpacked array with its own valid/ready handshake. The block is double-buffered: a fill bank collects the next frame while the output bank holds the current one, so a consumer that takes a frame at least every BUFFER_SIZE cycles sees a gap-free input stream.

## Interface
- WIDTH, 8, bits per element
- BUFFER_SIZE, 16, elements per frame (>= 2)
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- data_in  input  WIDTH  serial element
- data_in_valid  input  1  element present
- data_in_last  input  1  qualifies data_in; closes the current frame early (short frame)
- data_in_ready  output  1  block can accept an element this cycle
- data_out  output  WIDTH x [BUFFER_SIZE-1:0]  assembled frame; element k of the frame on data_out[k]
- data_out_count  output  $clog2(BUFFER_SIZE)+1  number of valid elements in data_out (1..BUFFER_SIZE)
- data_out_valid  output  1  frame present
- data_out_ready  input  1  consumer takes the frame

## Operation
- Input handshake: an element is accepted when data_in_valid && data_in_ready at the rising edge.
- Output handshake: a frame is taken when data_out_valid && data_out_ready at the rising edge.
- State
  - fill bank: BUFFER_SIZE x WIDTH registers.
  - fill_idx: counts 0..BUFFER_SIZE-1.
  - fill state: FILLING or FULL_WAIT.
  - output bank: registered data_out, data_out_count and data_out_valid.
- Accepted element is written to fill[fill_idx]; the first element after frame close goes to index 0.
- Frame close: occurs on acceptance when fill_idx == BUFFER_SIZE-1 or data_in_last == 1.
  - Closed frame length = fill_idx+1 at the time of close.
  - Slots above the last written index read as 0 in the presented frame.
  - The fill bank is cleared to 0 after every transfer to the output bank.
- Transfer rule: the output bank is free this cycle if !data_out_valid, or if data_out_valid && data_out_ready.
  - Close while the output bank is free: at the same edge the frame, including the element being accepted, is loaded into the output bank. data_out_valid = 1 next cycle. fill_idx -> 0. State stays FILLING.
  - Close while the output bank is busy: the frame stays in the fill bank. State -> FULL_WAIT.
- FULL_WAIT
  - data_in_ready = 0.
  - On the edge where the output bank is free, the fill bank moves to the output bank. data_out_valid stays or goes 1. fill_idx -> 0. State -> FILLING.
- FILLING: data_in_ready = 1.
  - data_in_ready is a decode of registered state only; no combinational path from data_out_ready.
- Output taken with nothing to transfer: data_out_valid -> 0. data_out and data_out_count hold their last values.
- Reset, asynchronous, any time including mid-frame:
  - Partial frame is discarded.
  - fill bank = 0, fill_idx = 0, state = FILLING.
  - data_out = all 0, data_out_count = 0, data_out_valid = 0.
  - data_in_ready = 1 once rst deasserts.

## Timing
- Latency: last element of a frame accepted at edge N with output bank free -> data_out_valid = 1 from edge N until the take.
- Throughput
  - 1 element/cycle sustained when the consumer takes each frame within BUFFER_SIZE cycles of presentation.
  - Otherwise the input stalls: exactly one extra frame is buffered, then data_in_ready = 0.
- Simultaneous events
  - Frame close plus take of the previous frame on the same edge: new frame replaces the old one. data_out_valid stays 1 with no bubble.
  - In FULL_WAIT, take at edge M: new frame visible after M. data_in_ready = 1 after M, so the first element of the next frame can be accepted at edge M+1.
- data_in_last on the element at index BUFFER_SIZE-1 is the same as a normal full close: count = BUFFER_SIZE.
- data_in_last is ignored unless the element is accepted.
- data_out is stable while data_out_valid && !data_out_ready.

## Test plan
WIDTH=8, BUFFER_SIZE=4 throughout.
- Basic fill: after reset, push 0x11,0x22,0x33,0x44 on back-to-back cycles with data_out_ready=1 -> one cycle after the 4th acceptance, data_out = {[0]=0x11,[1]=0x22,[2]=0x33,[3]=0x44}, count = 4, valid = 1 for exactly one cycle. data_in_ready = 1 throughout.
- Back-pressure: data_out_ready=0, push 8 elements 0x01..0x08 -> frame 0x01..0x04 held. After the 8th acceptance, data_in_ready = 0 and a 9th push stalls. Raise data_out_ready for one cycle -> data_out = 0x05..0x08 on the next cycle, then data_in_ready = 1.
- Streaming: 12 consecutive elements with data_out_ready=1 -> three frames with valid continuously high over frame boundaries and no input stall.
- Short frame: push 0xAA, then 0xBB with data_in_last=1 -> data_out = {0xAA,0xBB,0x00,0x00}, count = 2. The next element lands in data_out[0] of the following frame.
- Reset mid-frame: push 0x01,0x02, then pulse rst asynchronously (between edges) -> data_out_valid = 0 and data_out = 0 immediately. Then push 0x10,0x20,0x30,0x40 -> frame = 0x10..0x40 with no residue from 0x01/0x02.
- Hold stability: frame presented, data_out_ready=0 for 10 cycles while the next frame fills -> data_out, count and valid unchanged across all 10 cycles.

Source files
------------

// File: rtl/carousel_collector_if.sv
// Handshake bundle for carousel_collector: serial element stream in, parallel frame out.
interface carousel_collector_if #(
  parameter int WIDTH       = 8,
  parameter int BUFFER_SIZE = 16
);

  logic [WIDTH-1:0]              data_in;
  logic                          data_in_valid;
  logic                          data_in_last;
  logic                          data_in_ready;
  logic [WIDTH-1:0]              data_out [BUFFER_SIZE];
  logic [$clog2(BUFFER_SIZE):0]  data_out_count;
  logic                          data_out_valid;
  logic                          data_out_ready;

  // Producer/consumer side (the environment around the collector)
  modport master (
    output data_in,
    output data_in_valid,
    output data_in_last,
    output data_out_ready,
    input  data_in_ready,
    input  data_out,
    input  data_out_count,
    input  data_out_valid
  );

  // Collector side
  modport slave (
    input  data_in,
    input  data_in_valid,
    input  data_in_last,
    input  data_out_ready,
    output data_in_ready,
    output data_out,
    output data_out_count,
    output data_out_valid
  );

endinterface

// File: rtl/carousel_collector.sv
// carousel_collector: gathers BUFFER_SIZE serial elements into a parallel frame.
// Double-buffered: the fill bank collects the next frame while the output bank
// holds the frame currently offered to the consumer.
module carousel_collector #(
  parameter int WIDTH       = 8,
  parameter int BUFFER_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  carousel_collector_if.slave  bus
);

  localparam int IDX_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic {
    FILLING   = 1'b0,
    FULL_WAIT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] fill_bank  [BUFFER_SIZE];
  logic [WIDTH-1:0] frame_next [BUFFER_SIZE];
  logic [IDX_W-1:0] fill_idx;

  logic             accept;
  logic             last_slot;
  logic             close;
  logic             out_free;
  logic             take;
  logic             load;
  logic [CNT_W-1:0] close_count;

  assign accept      = bus.data_in_valid && bus.data_in_ready;
  assign last_slot   = (fill_idx == IDX_W'(BUFFER_SIZE - 1));
  assign close       = accept && (last_slot || bus.data_in_last);
  assign out_free    = !bus.data_out_valid || bus.data_out_ready;
  assign take        = bus.data_out_valid && bus.data_out_ready;
  // In FULL_WAIT fill_idx still points at the last written slot, so the same
  // length formula serves both the direct and the deferred transfer.
  assign close_count = CNT_W'(fill_idx) + CNT_W'(1);
  assign load        = ((state == FILLING) && close && out_free) ||
                       ((state == FULL_WAIT) && out_free);

  // Fill bank with the element being accepted merged in, so a closing element
  // reaches the output bank on the same edge it is accepted.
  always_comb begin
    for (int k = 0; k < BUFFER_SIZE; k++) begin
      frame_next[k] = fill_bank[k];
      if (accept && (fill_idx == IDX_W'(k))) begin
        frame_next[k] = bus.data_in;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILLING;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: a close against a busy output bank parks the frame in FULL_WAIT
  always_comb begin
    state_next = state;
    case (state)
      FILLING:   if (close && !out_free) state_next = FULL_WAIT;
      FULL_WAIT: if (out_free)           state_next = FILLING;
      default:                           state_next = FILLING;
    endcase
  end

  // Outputs: ready decodes registered state only, never data_out_ready
  always_comb begin
    bus.data_in_ready = (state == FILLING);
  end

  // Fill bank and write index; the bank is zeroed on every transfer so unused
  // slots of a short frame read as zero downstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < BUFFER_SIZE; k++) fill_bank[k] <= '0;
      fill_idx <= '0;
    end else if (load) begin
      for (int k = 0; k < BUFFER_SIZE; k++) fill_bank[k] <= '0;
      fill_idx <= '0;
    end else if (accept) begin
      fill_bank[fill_idx] <= bus.data_in;
      if (!close) begin
        fill_idx <= fill_idx + IDX_W'(1);
      end
    end
  end

  // Output bank: load a closed frame, or drop valid when taken with nothing behind it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < BUFFER_SIZE; k++) bus.data_out[k] <= '0;
      bus.data_out_count <= '0;
      bus.data_out_valid <= 1'b0;
    end else if (load) begin
      for (int k = 0; k < BUFFER_SIZE; k++) bus.data_out[k] <= frame_next[k];
      bus.data_out_count <= close_count;
      bus.data_out_valid <= 1'b1;
    end else if (take) begin
      bus.data_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_carousel_collector.sv
// Self-checking bench for carousel_collector (WIDTH=8, BUFFER_SIZE=4).
// Expected frames are built from the driven elements and queued; a monitor
// pops and compares them whenever the DUT hands a frame to the consumer.
module tb_carousel_collector;

  localparam int W  = 8;
  localparam int BS = 4;

  typedef struct {
    logic [BS*W-1:0] data;
    logic [2:0]      cnt;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  carousel_collector_if #(.WIDTH(W), .BUFFER_SIZE(BS)) bus ();

  carousel_collector #(.WIDTH(W), .BUFFER_SIZE(BS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int              total = 0;
  int              bad   = 0;
  frame_t          exp_q [$];
  logic [BS*W-1:0] m_frame = '0;
  int              m_idx   = 0;

  function automatic logic [BS*W-1:0] pack_out();
    logic [BS*W-1:0] p;
    for (int k = 0; k < BS; k++) p[k*W +: W] = bus.data_out[k];
    return p;
  endfunction

  // Scoreboard: compare every frame the consumer takes against the queue
  always @(negedge clk) begin
    if (!rst && bus.data_out_valid && bus.data_out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got frame %h count %0d, no frame expected",
                 pack_out(), bus.data_out_count);
      end else begin
        frame_t f;
        f = exp_q.pop_front();
        if (pack_out() !== f.data || bus.data_out_count !== f.cnt) begin
          bad++;
          $display("FAIL sb_frame: got %h count %0d, want %h count %0d",
                   pack_out(), bus.data_out_count, f.data, f.cnt);
        end
      end
    end
  end

  task automatic model_clear();
    exp_q.delete();
    m_frame = '0;
    m_idx   = 0;
  endtask

  task automatic do_reset();
    rst                = 1'b1;
    bus.data_in        = '0;
    bus.data_in_valid  = 1'b0;
    bus.data_in_last   = 1'b0;
    bus.data_out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Drive one element until accepted; called and returns at posedge+1
  task automatic push(input logic [W-1:0] d, input logic last, output int stalls);
    bit done;
    done              = 1'b0;
    stalls            = 0;
    bus.data_in       = d;
    bus.data_in_last  = last;
    bus.data_in_valid = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (bus.data_in_ready) done = 1'b1;
      else stalls++;
      @(posedge clk);
      #1;
    end
    bus.data_in_valid = 1'b0;
    bus.data_in_last  = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL push_timeout: element %h not accepted after %0d cycles, want acceptance", d, stalls);
    end else begin
      m_frame[m_idx*W +: W] = d;
      if (m_idx == BS-1 || last) begin
        frame_t f;
        f.data = m_frame;
        f.cnt  = 3'(m_idx + 1);
        exp_q.push_back(f);
        m_frame = '0;
        m_idx   = 0;
      end else begin
        m_idx++;
      end
    end
  endtask

  // Take frames until every expected frame has been seen and output is empty
  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    bus.data_out_ready = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !bus.data_out_valid) done = 1'b1;
    end
    bus.data_out_ready = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s_drain: %0d frames still expected, valid=%b, want 0 and 0",
               name, exp_q.size(), bus.data_out_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (bus.data_in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got %b want 1", bus.data_in_ready);
    end
    total++;
    if (bus.data_out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid: got %b want 0", bus.data_out_valid);
    end
    total++;
    if (bus.data_out_count !== 3'd0) begin
      bad++; $display("FAIL reset_count: got %0d want 0", bus.data_out_count);
    end
    total++;
    if (pack_out() !== '0) begin
      bad++; $display("FAIL reset_data: got %h want 0", pack_out());
    end
  endtask

  task automatic test_basic();
    int st;
    logic [W-1:0] vals [BS];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    bus.data_out_ready = 1'b1;
    for (int i = 0; i < BS; i++) begin
      push(vals[i], 1'b0, st);
      total++;
      if (st !== 0) begin
        bad++; $display("FAIL basic_stall: element %0d stalled %0d cycles, want 0", i, st);
      end
    end
    total++;
    if (bus.data_out_valid !== 1'b1 || pack_out() !== 32'h44332211 || bus.data_out_count !== 3'd4) begin
      bad++;
      $display("FAIL basic_frame: got valid=%b data=%h count=%0d, want 1 44332211 4",
               bus.data_out_valid, pack_out(), bus.data_out_count);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.data_out_valid !== 1'b0) begin
      bad++; $display("FAIL basic_one_cycle: valid got %b want 0", bus.data_out_valid);
    end
    bus.data_out_ready = 1'b0;
    drain("basic");
  endtask

  task automatic test_backpressure();
    int st;
    do_reset();
    bus.data_out_ready = 1'b0;
    for (int i = 0; i < 2*BS; i++) begin
      push(8'(i + 1), 1'b0, st);
      total++;
      if (st !== 0) begin
        bad++; $display("FAIL bp_stall: element %0d stalled %0d cycles, want 0", i, st);
      end
    end
    total++;
    if (bus.data_in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_ready_low: got %b want 0", bus.data_in_ready);
    end
    fork
      push(8'h09, 1'b0, st);
      begin
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          total++;
          if (bus.data_in_ready !== 1'b0 || pack_out() !== 32'h04030201) begin
            bad++;
            $display("FAIL bp_hold: cycle %0d ready=%b data=%h, want 0 04030201",
                     c, bus.data_in_ready, pack_out());
          end
        end
        @(posedge clk);
        #1 bus.data_out_ready = 1'b1;
        @(posedge clk);
        #1 bus.data_out_ready = 1'b0;
        total++;
        if (bus.data_out_valid !== 1'b1 || pack_out() !== 32'h08070605 ||
            bus.data_out_count !== 3'd4 || bus.data_in_ready !== 1'b1) begin
          bad++;
          $display("FAIL bp_second: got valid=%b data=%h count=%0d ready=%b, want 1 08070605 4 1",
                   bus.data_out_valid, pack_out(), bus.data_out_count, bus.data_in_ready);
        end
      end
    join
    total++;
    if (st !== 4) begin
      bad++; $display("FAIL bp_ninth_stall: got %0d stall cycles want 4", st);
    end
    drain("bp");
  endtask

  task automatic test_streaming();
    int st;
    do_reset();
    for (int i = 0; i < 3*BS; i++) begin
      bus.data_out_ready = (i == 2*BS-1) || (i == 3*BS-1);
      push(8'(8'h30 + i), 1'b0, st);
      total++;
      if (st !== 0) begin
        bad++; $display("FAIL stream_stall: element %0d stalled %0d cycles, want 0", i, st);
      end
      if (i >= BS-1) begin
        total++;
        if (bus.data_out_valid !== 1'b1) begin
          bad++; $display("FAIL stream_valid: after element %0d valid got %b want 1", i, bus.data_out_valid);
        end
      end
    end
    bus.data_out_ready = 1'b0;
    drain("stream");
  endtask

  task automatic test_short_frame();
    int st;
    do_reset();
    bus.data_out_ready = 1'b1;
    push(8'hAA, 1'b0, st);
    push(8'hBB, 1'b1, st);
    total++;
    if (bus.data_out_valid !== 1'b1 || pack_out() !== 32'h0000BBAA || bus.data_out_count !== 3'd2) begin
      bad++;
      $display("FAIL short_frame: got valid=%b data=%h count=%0d, want 1 0000bbaa 2",
               bus.data_out_valid, pack_out(), bus.data_out_count);
    end
    push(8'hCC, 1'b0, st);
    push(8'hDD, 1'b1, st);
    total++;
    if (pack_out() !== 32'h0000DDCC || bus.data_out_count !== 3'd2) begin
      bad++;
      $display("FAIL short_next: got data=%h count=%0d, want 0000ddcc 2", pack_out(), bus.data_out_count);
    end
    // last without valid must not close anything
    bus.data_in_last = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    push(8'h01, 1'b0, st);
    push(8'h02, 1'b0, st);
    push(8'h03, 1'b0, st);
    push(8'h04, 1'b1, st);
    total++;
    if (pack_out() !== 32'h04030201 || bus.data_out_count !== 3'd4) begin
      bad++;
      $display("FAIL short_last_full: got data=%h count=%0d, want 04030201 4", pack_out(), bus.data_out_count);
    end
    drain("short");
  endtask

  task automatic test_reset_mid_frame();
    int st;
    do_reset();
    bus.data_out_ready = 1'b0;
    for (int i = 0; i < BS; i++) push(8'(8'h0A + i), 1'b0, st);
    push(8'h01, 1'b0, st);
    push(8'h02, 1'b0, st);
    #1 rst = 1'b1;
    model_clear();
    #1;
    total++;
    if (bus.data_out_valid !== 1'b0 || pack_out() !== '0 || bus.data_out_count !== 3'd0) begin
      bad++;
      $display("FAIL rstmid_async: got valid=%b data=%h count=%0d, want 0 0 0",
               bus.data_out_valid, pack_out(), bus.data_out_count);
    end
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (bus.data_in_ready !== 1'b1) begin
      bad++; $display("FAIL rstmid_ready: got %b want 1", bus.data_in_ready);
    end
    for (int i = 0; i < BS; i++) push(8'(8'h10 * (i + 1)), 1'b0, st);
    total++;
    if (pack_out() !== 32'h40302010 || bus.data_out_count !== 3'd4) begin
      bad++;
      $display("FAIL rstmid_frame: got data=%h count=%0d, want 40302010 4", pack_out(), bus.data_out_count);
    end
    drain("rstmid");
  endtask

  task automatic test_hold();
    int st;
    do_reset();
    bus.data_out_ready = 1'b0;
    for (int i = 0; i < BS; i++) push(8'(8'hA1 + i), 1'b0, st);
    fork
      for (int i = 0; i < BS; i++) push(8'(8'hB1 + i), 1'b0, st);
      begin
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          total++;
          if (bus.data_out_valid !== 1'b1 || pack_out() !== 32'hA4A3A2A1 || bus.data_out_count !== 3'd4) begin
            bad++;
            $display("FAIL hold_stable: cycle %0d valid=%b data=%h count=%0d, want 1 a4a3a2a1 4",
                     c, bus.data_out_valid, pack_out(), bus.data_out_count);
          end
        end
      end
    join
    @(posedge clk);
    #1;
    drain("hold");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_streaming();
    test_short_frame();
    test_reset_mid_frame();
    test_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
